// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
//   Two-master / one-slave AXI4 read-channel arbiter. Master 0 is the
//   instruction fetch unit and master 1 is the load/store unit. Only one read
//   transaction is in flight at a time. The winner's AR fields are latched and
//   replayed to the slave. R beats are forwarded combinationally to the owner
//   until rlast, and the beat count is checked against the latched arlen.
//
//   Ports
//     clk, rst                      clock, asynchronous active-high reset
//     mN_ar{valid,ready,addr,len,size,burst}   master N read address channel
//     mN_r{valid,ready,data,resp,last,id}      master N read data channel
//     s_ar{valid,ready,addr,id,len,size,burst} slave read address channel
//     s_r{valid,ready,data,resp,last,id}       slave read data channel
//     grant    index of the current or last owner
//     busy     a transaction is in flight
//     len_err  one-cycle pulse after an rlast beat whose count mismatched arlen
//
//   Configuration
//     AXI_ARB_RR_EN  defined: round-robin between the two masters.
//                    undefined: fixed priority, master 1 over master 0.
module axi_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    input  logic [ADDR_WIDTH-1:0] m0_araddr,
    input  logic [7:0]            m0_arlen,
    input  logic [2:0]            m0_arsize,
    input  logic [1:0]            m0_arburst,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic                  m0_rlast,
    output logic [3:0]            m0_rid,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    input  logic [ADDR_WIDTH-1:0] m1_araddr,
    input  logic [7:0]            m1_arlen,
    input  logic [2:0]            m1_arsize,
    input  logic [1:0]            m1_arburst,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic                  m1_rlast,
    output logic [3:0]            m1_rid,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    output logic [ADDR_WIDTH-1:0] s_araddr,
    output logic [3:0]            s_arid,
    output logic [7:0]            s_arlen,
    output logic [2:0]            s_arsize,
    output logic [1:0]            s_arburst,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rlast,
    input  logic [3:0]            s_rid,
    output logic                  grant,
    output logic                  busy,
    output logic                  len_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t     state;
    logic [7:0] beat_cnt;
    logic       win;
    logic       any_req;
    logic       accept;
    logic       in_data;
    logic       sel0;
    logic       sel1;
    logic       beat;

    assign any_req = m0_arvalid | m1_arvalid;

`ifdef AXI_ARB_RR_EN
    // rr_ptr names the master that wins when both request.
    logic rr_ptr;
    assign win = (m0_arvalid & m1_arvalid) ? rr_ptr : m1_arvalid;
`else
    assign win = m1_arvalid;
`endif

    // arready is combinational from arvalid, so it is also gated by rst to
    // keep every output at 0 while reset is held.
    assign accept     = (state == IDLE) & any_req & ~rst;
    assign m0_arready = accept & ~win;
    assign m1_arready = accept & win;

    assign in_data  = (state == DATA);
    assign sel0     = in_data & ~grant;
    assign sel1     = in_data & grant;
    assign s_rready = (sel0 & m0_rready) | (sel1 & m1_rready);
    assign beat     = in_data & s_rvalid & s_rready;

    assign m0_rvalid = sel0 & s_rvalid;
    assign m0_rdata  = sel0 ? s_rdata : '0;
    assign m0_rresp  = sel0 ? s_rresp : 2'b00;
    assign m0_rlast  = sel0 & s_rlast;
    assign m0_rid    = sel0 ? s_rid : 4'd0;
    assign m1_rvalid = sel1 & s_rvalid;
    assign m1_rdata  = sel1 ? s_rdata : '0;
    assign m1_rresp  = sel1 ? s_rresp : 2'b00;
    assign m1_rlast  = sel1 & s_rlast;
    assign m1_rid    = sel1 ? s_rid : 4'd0;

    assign s_arid = {3'b000, grant};
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= 1'b0;
            s_arvalid <= 1'b0;
            s_araddr  <= '0;
            s_arlen   <= 8'd0;
            s_arsize  <= 3'd0;
            s_arburst <= 2'd0;
            beat_cnt  <= 8'd0;
            len_err   <= 1'b0;
`ifdef AXI_ARB_RR_EN
            rr_ptr    <= 1'b0;
`endif
        end else begin
            len_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant     <= win;
                        s_araddr  <= win ? m1_araddr  : m0_araddr;
                        s_arlen   <= win ? m1_arlen   : m0_arlen;
                        s_arsize  <= win ? m1_arsize  : m0_arsize;
                        s_arburst <= win ? m1_arburst : m0_arburst;
                        beat_cnt  <= 8'd0;
                        s_arvalid <= 1'b1;
                        state     <= ADDR;
`ifdef AXI_ARB_RR_EN
                        rr_ptr    <= ~win;
`endif
                    end
                end
                ADDR: begin
                    if (s_arready) begin
                        s_arvalid <= 1'b0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        // beat_cnt holds the beats already seen, so on a
                        // correct burst it equals arlen at the rlast beat.
                        if (s_rlast) begin
                            len_err <= (beat_cnt != s_arlen);
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
    logic [31:0] m0_araddr, m0_rdata;
    logic [7:0]  m0_arlen;
    logic [2:0]  m0_arsize;
    logic [1:0]  m0_arburst, m0_rresp;
    logic [3:0]  m0_rid;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
    logic [31:0] m1_araddr, m1_rdata;
    logic [7:0]  m1_arlen;
    logic [2:0]  m1_arsize;
    logic [1:0]  m1_arburst, m1_rresp;
    logic [3:0]  m1_rid;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [31:0] s_araddr, s_rdata;
    logic [3:0]  s_arid, s_rid;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst, s_rresp;
    logic        grant, busy, len_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
        .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
        .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rid(m0_rid),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
        .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
        .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rid(m1_rid),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid),
        .grant(grant), .busy(busy), .len_err(len_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow #1 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_arvalid = 0; m0_araddr = 0; m0_arlen = 0; m0_arsize = 0; m0_arburst = 0; m0_rready = 0;
        m1_arvalid = 0; m1_araddr = 0; m1_arlen = 0; m1_arsize = 0; m1_arburst = 0; m1_rready = 0;
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rlast = 0; s_rid = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic addr_phase();
        s_arready = 1;
        tick();
        s_arready = 0;
    endtask

    task automatic slave_beat(input logic [31:0] d, input logic last, input logic [3:0] id);
        s_rvalid = 1; s_rdata = d; s_rlast = last; s_rid = id; s_rresp = 2'b00;
        #1;
    endtask

    initial begin
        logic exp_w;
        rst = 1;
        clear_inputs();
        #2;
        // ---- reset state ----
        chk("rst_busy", busy, 0);
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_grant", grant, 0);
        chk("rst_len_err", len_err, 0);
        do_reset();

        // ---- single fetch ----
        m0_arvalid = 1; m0_araddr = 32'h2000_0000; m0_arlen = 0; m0_arsize = 3'd2; m0_arburst = 2'd1;
        #1;
        chk("sf_m0_arready", m0_arready, 1);
        chk("sf_m1_arready", m1_arready, 0);
        chk("sf_s_arvalid_c0", s_arvalid, 0);
        tick();
        m0_arvalid = 0;
        #1;
        chk("sf_s_arvalid_c1", s_arvalid, 1);
        chk("sf_s_araddr", s_araddr, 32'h2000_0000);
        chk("sf_s_arsize", {29'd0, s_arsize}, 2);
        chk("sf_s_arid", {28'd0, s_arid}, 0);
        chk("sf_busy", busy, 1);
        chk("sf_m0_arready_addr", m0_arready, 0);
        addr_phase();
        m0_rready = 1;
        slave_beat(32'h0010_0093, 1, 4'd0);
        chk("sf_m0_rvalid", m0_rvalid, 1);
        chk("sf_m0_rdata", m0_rdata, 32'h0010_0093);
        chk("sf_m0_rlast", m0_rlast, 1);
        chk("sf_s_rready", s_rready, 1);
        chk("sf_m1_rvalid", m1_rvalid, 0);
        chk("sf_m1_rdata", m1_rdata, 0);
        tick();
        s_rvalid = 0; s_rlast = 0; m0_rready = 0;
        #1;
        chk("sf_busy_after", busy, 0);
        chk("sf_len_err", len_err, 0);
        chk("sf_m0_rvalid_after", m0_rvalid, 0);

        // ---- contention, fresh reset so the RR pointer favours master 0 ----
        do_reset();
        m0_arvalid = 1; m0_araddr = 32'h0000_1000; m0_arlen = 0;
        m1_arvalid = 1; m1_araddr = 32'h0000_2000; m1_arlen = 0;
        m0_rready = 1; m1_rready = 1;
        for (int t = 0; t < 4; t++) begin
`ifdef AXI_ARB_RR_EN
            exp_w = t[0];
`else
            exp_w = 1'b1;
`endif
            #1;
            chk("ct_m0_arready", m0_arready, {31'd0, ~exp_w});
            chk("ct_m1_arready", m1_arready, {31'd0, exp_w});
            tick();
            chk("ct_grant", grant, {31'd0, exp_w});
            chk("ct_s_araddr", s_araddr, exp_w ? 32'h0000_2000 : 32'h0000_1000);
            addr_phase();
            slave_beat(32'hC000_0000 + t, 1, {3'd0, exp_w});
            chk("ct_m1_rvalid", m1_rvalid, {31'd0, exp_w});
            chk("ct_m0_rvalid", m0_rvalid, {31'd0, ~exp_w});
            chk("ct_arready_in_data", m0_arready | m1_arready, 0);
            tick();
            s_rvalid = 0; s_rlast = 0;
        end
        clear_inputs();
        tick();

        // ---- burst with backpressure ----
        m1_arvalid = 1; m1_araddr = 32'h0000_4000; m1_arlen = 3;
        #1;
        chk("bp_m1_arready", m1_arready, 1);
        tick();
        m1_arvalid = 0;
        chk("bp_s_arlen", {24'd0, s_arlen}, 3);
        chk("bp_s_arid", {28'd0, s_arid}, 1);
        addr_phase();
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                m1_rready = 0;
                slave_beat(32'hA0 + b, 0, 4'd1);
                chk("bp_stall_s_rready", s_rready, 0);
                chk("bp_stall_m1_rvalid", m1_rvalid, 1);
                tick();
            end
            m1_rready = 1;
            slave_beat(32'hA0 + b, b == 3, 4'd1);
            chk("bp_s_rready", s_rready, 1);
            chk("bp_m1_rdata", m1_rdata, 32'hA0 + b);
            chk("bp_m0_rvalid", m0_rvalid, 0);
            tick();
            s_rvalid = 0; s_rlast = 0;
        end
        #1;
        chk("bp_len_err", len_err, 0);
        chk("bp_busy", busy, 0);
        m1_rready = 0;

        // ---- short burst: arlen=3, rlast on the third beat ----
        m0_arvalid = 1; m0_araddr = 32'h0000_5000; m0_arlen = 3;
        tick();
        m0_arvalid = 0;
        addr_phase();
        m0_rready = 1;
        for (int b = 0; b < 3; b++) begin
            slave_beat(32'hB0 + b, b == 2, 4'd0);
            chk("sb_len_err_during", len_err, 0);
            tick();
            s_rvalid = 0; s_rlast = 0;
        end
        #1;
        chk("sb_len_err_pulse", len_err, 1);
        chk("sb_busy", busy, 0);
        tick();
        chk("sb_len_err_clear", len_err, 0);
        m0_rready = 0;

        // ---- stalled slave ----
        m0_arvalid = 1; m0_araddr = 32'h0000_3000; m0_arlen = 0;
        tick();
        m0_araddr = 32'h0000_3100;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("st_s_arvalid", s_arvalid, 1);
            chk("st_s_araddr", s_araddr, 32'h0000_3000);
            chk("st_m0_arready", m0_arready, 0);
            tick();
        end
        m0_arvalid = 0;
        addr_phase();
        m0_rready = 1;
        slave_beat(32'h55, 1, 4'd0);
        chk("st_m0_rvalid", m0_rvalid, 1);
        tick();
        s_rvalid = 0; s_rlast = 0; m0_rready = 0;

        // ---- reset mid-burst ----
        m1_arvalid = 1; m1_araddr = 32'h0000_6000; m1_arlen = 3;
        tick();
        m1_arvalid = 0;
        addr_phase();
        m1_rready = 1;
        for (int b = 0; b < 2; b++) begin
            slave_beat(32'hD0 + b, 0, 4'd1);
            tick();
        end
        slave_beat(32'hD2, 0, 4'd1);
        chk("rm_m1_rvalid_pre", m1_rvalid, 1);
        m0_arvalid = 1; m0_araddr = 32'h0000_7000; m0_arlen = 0;
        rst = 1;
        #1;
        chk("rm_m1_rvalid", m1_rvalid, 0);
        chk("rm_s_rready", s_rready, 0);
        chk("rm_busy", busy, 0);
        chk("rm_grant", grant, 0);
        chk("rm_s_arvalid", s_arvalid, 0);
        chk("rm_s_araddr", s_araddr, 0);
        chk("rm_m0_arready", m0_arready, 0);
        chk("rm_m1_rdata", m1_rdata, 0);
        tick();
        s_rvalid = 0; m1_rready = 0;
        rst = 0;
        #1;
        chk("rm_post_m0_arready", m0_arready, 1);
        tick();
        m0_arvalid = 0;
        chk("rm_post_s_arvalid", s_arvalid, 1);
        chk("rm_post_s_araddr", s_araddr, 32'h0000_7000);
        chk("rm_post_grant", grant, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
